// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, NOP encoding and fetch state enum
package riscv_pkg;

  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next PC adder with word-alignment check
module pc_next_logic (
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic [31:0] imm_ext_i,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  logic [31:0] sum;

  // Modulo-2^32 add; a misaligned result is flagged and then forced onto a word boundary.
  assign sum        = pc_i + (pc_src_i ? imm_ext_i : 32'd4);
  assign misalign_o = |sum[1:0];
  assign pc_next_o  = {sum[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM (REQ/WAIT/HOLD)
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc_out,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic        misalign_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_out_q;
  logic         misalign_q;
  logic [31:0]  pc_d;
  logic         misalign_d;

  pc_next_logic u_pc_next (
    .pc_i       (pc_q),
    .pc_src_i   (pc_src),
    .imm_ext_i  (imm_ext),
    .pc_next_o  (pc_d),
    .misalign_o (misalign_d)
  );

  // Inputs irrelevant to the current state are simply not looked at, which drops stray responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (imem_req_ready) state_q <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q  <= imem_rsp_data;
            pc_out_q <= pc_q;
            state_q  <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (instr_ready) begin
            pc_q       <= pc_d;
            misalign_q <= misalign_q | misalign_d;
            state_q    <= FETCH_REQ;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  // Valids are gated by rst so nothing is offered while reset is held.
  assign imem_req_valid = (state_q == FETCH_REQ)  && !rst;
  assign instr_valid    = (state_q == FETCH_HOLD) && !rst;
  assign imem_req_addr  = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign pc_out         = pc_out_q;
  assign misalign_err   = misalign_q;

endmodule
